uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one UART transmitter (legal range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the watchdog limit in clk cycles (used only when REQ-030 is compiled in).
REQ-003 clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid  input  NREQ  SHALL be a per-requester "byte pending" flag.
REQ-006 req_data  input  8*NREQ  SHALL carry the bytes; requester k uses bits [8k+7:8k].
REQ-007 req_ready  output  NREQ  SHALL pulse high for one cycle on the accepted requester's bit.
REQ-008 tx_start  output  1  SHALL be a one-cycle start pulse to the transmitter.
REQ-009 tx_data  output  8  SHALL hold the byte being sent.
REQ-010 tx_busy  input  1  SHALL indicate that the transmitter is shifting.
REQ-011 tx_done  input  1  SHALL be the transmitter's one-cycle frame-complete pulse.
REQ-012 grant_id  output  clog2(NREQ)  SHALL give the index of the current or last granted requester.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 timeout_err  output  1  SHALL pulse high for one cycle on a watchdog expiry.

Function
REQ-015 The FSM SHALL have two states, IDLE and WAIT.
REQ-016 In IDLE, when any req_valid bit is 1 and tx_busy is 0, the block SHALL grant the winner on the next edge:
- pulse req_ready[winner];
- latch req_data[winner] into tx_data;
- pulse tx_start;
- load grant_id;
- enter WAIT.
REQ-017 Acceptance latency SHALL be exactly 1 cycle: a request sampled in IDLE at cycle N produces req_ready, tx_start and valid tx_data at N+1.
REQ-018 The winner SHALL be the first requester with req_valid=1 found by searching upward from pointer ptr, wrapping NREQ-1 to 0.
REQ-019 ptr SHALL update to (winner+1) mod NREQ on each grant; when winner = NREQ-1, ptr SHALL wrap to 0.
REQ-020 In IDLE with tx_busy=1, no grant SHALL occur, regardless of req_valid.
REQ-021 In WAIT, req_valid SHALL be ignored, and no req_ready or tx_start SHALL be issued.
REQ-022 In WAIT, tx_done=1 SHALL return the FSM to IDLE on the next edge, so the earliest next grant is 2 cycles after tx_done.
REQ-023 tx_data SHALL hold its value until the next grant.
REQ-024 A requester deasserting req_valid before it is granted SHALL be treated as a withdrawn request and SHALL NOT be granted.
REQ-025 tx_done received while in IDLE SHALL be ignored.
REQ-026 At most one req_ready bit SHALL be high in any cycle.

Reset
REQ-027 With rst=1 at a clk edge, the block SHALL set:
- state = IDLE, ptr = 0;
- tx_data = 0x00, grant_id = 0;
- req_ready = 0, tx_start = 0, busy = 0, timeout_err = 0.
REQ-028 Reset asserted in WAIT SHALL abandon the transfer without any notification to the requester.
REQ-029 During reset, inputs SHALL be ignored; the first grant is possible at the first edge after rst falls.

Configuration
REQ-030 With macro UART_TX_ARB_TIMEOUT_EN defined:
- a counter SHALL clear on entry to WAIT and increment each WAIT cycle;
- if the count reaches TIMEOUT_CYCLES-1 without tx_done, the FSM SHALL return to IDLE and pulse timeout_err for one cycle;
- tx_done in the same cycle as expiry SHALL take priority, and then no timeout_err is raised.
REQ-031 Without UART_TX_ARB_TIMEOUT_EN, WAIT SHALL persist until tx_done, timeout_err SHALL be tied to 0, and no counter logic SHALL be present.

Verification
REQ-032 After reset: req_valid=0b0100, req_data[2]=0xA5 -> next cycle req_ready=0b0100, tx_start=1, tx_data=0xA5, grant_id=2.
REQ-033 req_valid=0b1111 held, tx_done returned 20 cycles after each tx_start -> grant order 0,1,2,3,0 (ptr wrap).
REQ-034 In IDLE, req_valid=0b0001 with tx_busy=1 for 5 cycles -> no tx_start; tx_busy falls -> tx_start exactly 1 cycle later.
REQ-035 Second request arrives in WAIT -> no req_ready until 2 cycles after tx_done; tx_done while in IDLE -> no effect.
REQ-036 rst asserted in WAIT -> next cycle busy=0 and ptr=0; then req_valid=0b0010 -> grant_id=1.
REQ-037 With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, tx_done withheld -> timeout_err pulses once, 16 cycles after tx_start, and busy=0 on the next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NREQ byte sources share one
// UART transmitter. Each grant pulses req_ready/tx_start for one cycle and
// latches the winning byte into tx_data. The block then waits in WAIT until
// the transmitter reports tx_done.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add a WAIT-state watchdog
// that abandons a transfer after TIMEOUT_CYCLES cycles and pulses timeout_err.
module uart_tx_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned IDW = $clog2(NREQ);

    // Elaboration-time parameter range checks
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("uart_tx_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] scan_idx;
    logic [IDW-1:0] ptr_next;
    logic [7:0]     data_arr [NREQ];

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
`endif

    // Split the flat data bus into one byte per requester
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[8*i +: 8];
        end
    end

    // Round-robin search: first valid requester at or above ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = IDW'((32'(ptr) + i) % NREQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Pointer moves just past the winner, wrapping from NREQ-1 back to 0
    always_comb begin
        ptr_next = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Arbiter FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            tx_data   <= 8'h00;
            grant_id  <= '0;
            req_ready <= '0;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            req_ready <= '0;
            tx_start  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (win_found && !tx_busy) begin
                        state     <= WAIT;
                        busy      <= 1'b1;
                        req_ready <= NREQ'(1) << win_idx;
                        tx_start  <= 1'b1;
                        tx_data   <= data_arr[win_idx];
                        grant_id  <= win_idx;
                        ptr       <= ptr_next;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
            endcase
        end
    end

`ifndef UART_TX_ARB_TIMEOUT_EN
    // No watchdog in this build
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus a randomized run,
// all checked against a transaction-level reference model of the arbiter.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int GAP  = 12;
`else
    localparam int GAP  = 20;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              tx_done;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state and expected outputs after the next edge
    bit              m_wait;
    int              m_ptr;
    int              m_cnt;
    logic [NREQ-1:0] e_ready;
    logic            e_start;
    logic [7:0]      e_data;
    logic [1:0]      e_gid;
    logic            e_busy;
    logic            e_terr;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Advance the model by one edge using the inputs currently applied
    function automatic void model_step();
        int best;
        int bestd;
        int d;
        e_ready = '0;
        e_start = 1'b0;
        e_terr  = 1'b0;
        if (rst) begin
            m_wait = 1'b0; m_ptr = 0; m_cnt = 0;
            e_data = 8'h00; e_gid = 2'd0;
        end else if (!m_wait) begin
            best = -1; bestd = NREQ;
            for (int k = 0; k < NREQ; k++) begin
                if (req_valid[k]) begin
                    d = (k - m_ptr + NREQ) % NREQ;
                    if (d < bestd) begin bestd = d; best = k; end
                end
            end
            if (best >= 0 && !tx_busy) begin
                e_ready = 4'(1 << best);
                e_start = 1'b1;
                e_data  = 8'((req_data >> (8 * best)) & 32'hFF);
                e_gid   = 2'(best);
                m_ptr   = (best + 1) % NREQ;
                m_wait  = 1'b1;
                m_cnt   = 0;
            end
        end else begin
            if (tx_done) m_wait = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (m_cnt == TMO - 1) begin m_wait = 1'b0; e_terr = 1'b1; end
            else m_cnt++;
`endif
        end
        e_busy = m_wait;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < NREQ; k++) req_data[8*k +: 8] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({req_ready, tx_start, tx_data, grant_id, busy, timeout_err} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state: got ready=%b start=%b data=%h gid=%0d busy=%b terr=%b, want all 0",
                     req_ready, tx_start, tx_data, grant_id, busy, timeout_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_grant();
        req_valid = 4'b0100; req_data = 32'h11A5_2233;
        tick();
        n_cmp++;
        if (req_ready !== 4'b0100 || tx_start !== 1'b1 || tx_data !== 8'hA5 || grant_id !== 2'd2) begin
            n_bad++;
            $display("FAIL single_grant: got ready=%b start=%b data=%h gid=%0d, want 0100 1 a5 2",
                     req_ready, tx_start, tx_data, grant_id);
        end
        req_valid = '0;
        tick();
        n_cmp++;
        if (req_ready !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL single_pulse: got ready=%b start=%b busy=%b data=%h, want 0000 0 1 a5",
                     req_ready, tx_start, busy, tx_data);
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int extra;
        int waited;
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 4'b1111; rand_data();
        extra = 0;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            do begin tick(); waited++; end while (!tx_start && waited < 50);
            n_cmp++;
            if (tx_start !== 1'b1 || grant_id !== 2'(order[g]) || req_ready !== 4'(1 << order[g]) ||
                tx_data !== req_data[8*order[g] +: 8]) begin
                n_bad++;
                $display("FAIL rr_grant%0d: got start=%b gid=%0d ready=%b data=%h, want 1 %0d %b %h",
                         g, tx_start, grant_id, req_ready, tx_data, order[g],
                         4'(1 << order[g]), req_data[8*order[g] +: 8]);
            end
            for (int c = 0; c < GAP; c++) begin
                tick();
                if (tx_start || req_ready != 0) extra++;
            end
            tx_done = 1'b1; tick(); tx_done = 1'b0;
            if (tx_start || req_ready != 0) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL rr_wait_quiet: got %0d grants while waiting, want 0", extra);
        end
        req_valid = '0; tick();
    endtask

    task automatic test_busy_block();
        int early;
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 4'b0001; tx_busy = 1'b1; early = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (tx_start !== 1'b0) early++;
        end
        n_cmp++;
        if (early !== 0) begin
            n_bad++;
            $display("FAIL busy_block: got %0d starts while tx_busy, want 0", early);
        end
        tx_busy = 1'b0;
        tick();
        n_cmp++;
        if (tx_start !== 1'b1 || req_ready !== 4'b0001 || grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL busy_release: got start=%b ready=%b gid=%0d, want 1 0001 0",
                     tx_start, req_ready, grant_id);
        end
    endtask

    // Continues from the grant of requester 0 left by test_busy_block
    task automatic test_wait_ignore();
        int early;
        req_valid = 4'b0010; early = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (req_ready !== 4'b0000) early++;
        end
        n_cmp++;
        if (early !== 0) begin
            n_bad++;
            $display("FAIL wait_ignore: got %0d grants in WAIT, want 0", early);
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        n_cmp++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_plus1: got ready=%b busy=%b, want 0000 0", req_ready, busy);
        end
        tick();
        n_cmp++;
        if (req_ready !== 4'b0010 || grant_id !== 2'd1) begin
            n_bad++;
            $display("FAIL done_plus2: got ready=%b gid=%0d, want 0010 1", req_ready, grant_id);
        end
        req_valid = '0;
        tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_done: got busy=%b start=%b, want 0 0", busy, tx_start);
        end
        req_valid = 4'b1000; tick();
        n_cmp++;
        if (tx_start !== 1'b1 || grant_id !== 2'd3) begin
            n_bad++;
            $display("FAIL idle_done_grant: got start=%b gid=%0d, want 1 3", tx_start, grant_id);
        end
        req_valid = '0;
        tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
    endtask

    task automatic test_reset_in_wait();
        req_valid = 4'b0001; tick();
        req_valid = 4'b0011; tick();
        rst = 1'b1; tick();
        n_cmp++;
        if (busy !== 1'b0 || req_ready !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_in_wait: got busy=%b ready=%b start=%b data=%h gid=%0d, want 0 0000 0 00 0",
                     busy, req_ready, tx_start, tx_data, grant_id);
        end
        rst = 1'b0; tick();
        // ptr was 1 before reset, so winning requester 0 shows ptr returned to 0
        n_cmp++;
        if (tx_start !== 1'b1 || grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_ptr: got start=%b gid=%0d, want 1 0", tx_start, grant_id);
        end
        req_valid = '0;
        tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
        req_valid = 4'b0010; tick();
        n_cmp++;
        if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL post_rst_grant: got gid=%0d ready=%b, want 1 0010", grant_id, req_ready);
        end
        req_valid = '0;
        tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
    endtask

    task automatic test_watchdog();
        int seen;
        int pulses;
        req_valid = 4'b0100; tick(); req_valid = '0;
        seen = -1; pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (timeout_err) begin
                pulses++;
                if (seen < 0) seen = c;
            end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        n_cmp++;
        if (seen !== TMO || pulses !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL watchdog: got first=%0d pulses=%0d busy=%b, want %0d 1 0", seen, pulses, busy, TMO);
        end
        // tx_done on the expiry cycle wins over the watchdog
        req_valid = 4'b0001; tick(); req_valid = '0;
        for (int c = 1; c < TMO; c++) tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        n_cmp++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_vs_expiry: got terr=%b busy=%b, want 0 0", timeout_err, busy);
        end
`else
        n_cmp++;
        if (pulses !== 0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL no_watchdog: got pulses=%0d busy=%b, want 0 1", pulses, busy);
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
`endif
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = 4'($urandom_range(0, 15));
            tx_busy   = ($urandom_range(0, 3) == 0);
            tx_done   = ($urandom_range(0, 9) == 0);
            rand_data();
            tick();
            n_cmp++;
            if (req_ready !== e_ready || tx_start !== e_start) begin
                n_bad++;
                $display("FAIL rnd_grant@%0d: got ready=%b start=%b, want %b %b", c, req_ready, tx_start, e_ready, e_start);
            end
            n_cmp++;
            if (tx_data !== e_data || grant_id !== e_gid) begin
                n_bad++;
                $display("FAIL rnd_data@%0d: got data=%h gid=%0d, want %h %0d", c, tx_data, grant_id, e_data, e_gid);
            end
            n_cmp++;
            if (busy !== e_busy || timeout_err !== e_terr || $countones(req_ready) > 1) begin
                n_bad++;
                $display("FAIL rnd_status@%0d: got busy=%b terr=%b ready=%b, want %b %b", c, busy, timeout_err, req_ready, e_busy, e_terr);
            end
        end
        rst = 1'b0; tx_done = 1'b0; tx_busy = 1'b0; req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_busy_block();
        test_wait_ignore();
        test_reset_in_wait();
        test_watchdog();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
